key_debounce_ctrl: RTL and testbench
====================================

# key_debounce_ctrl

Conditions the raw DE10-Nano push-button before it reaches the HPS system's `pio_key_input_export` input, so software sees a clean, glitch-free level. The block does the following:

- synchronises the asynchronous board key into the system clock domain;
- debounces it with a stability counter;
- emits one-cycle press, release and long-press event pulses for fabric logic.

It sits directly upstream of the GreenMachine SoC instance, in the same 50 MHz domain.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `DEBOUNCE_MS`, 20, required input stability time in ms.
- `LONG_MS`, 1000, hold time that qualifies a long press, in ms.
- `ACTIVE_LOW`, 1, 1 = the raw key reads 0 when pressed.

Ports:
- `clk_clk`  in  1  system clock. One clock only; every flop is in this domain.
- `reset_reset`  in  1  reset, asynchronous and active-high.
- `key_raw`  in  1  asynchronous board key pin.
- `key_level`  out  1  debounced pressed level (1 = pressed). Drives `pio_key_input_export`.
- `press_pulse`  out  1  one-cycle pulse on a debounced press.
- `release_pulse`  out  1  one-cycle pulse on a debounced release.
- `long_pulse`  out  1  one-cycle pulse when a hold reaches `LONG_MS`.
- `key_long`  out  1  high from `long_pulse` until release.

## Operation
- Derived constants:
  - `DB_CYC` = `CLK_HZ`/1000*`DEBOUNCE_MS`.
  - `LONG_CYC` = `CLK_HZ`/1000*`LONG_MS`.
  - Elaboration error if `DB_CYC` < 1 or `LONG_CYC` <= `DB_CYC`.
  - Counter widths are `$clog2(LONG_CYC+1)`.
- Input path:
  - `key_raw` passes through a 2-FF synchroniser.
  - It is then inverted if `ACTIVE_LOW`, giving `k` (1 = pressed).
- FSM states: IDLE, PRESS_DB, PRESSED, RELEASE_DB.
  - IDLE: when `k`=1, go to PRESS_DB and clear the debounce counter.
  - PRESS_DB: when `k`=0, return to IDLE (bounce, no pulse). When `k` has been 1 for `DB_CYC` consecutive cycles, go to PRESSED, set `key_level`, pulse `press_pulse`.
  - PRESSED: when `k`=0, go to RELEASE_DB and clear the debounce counter.
  - RELEASE_DB: when `k`=1, return to PRESSED (no pulse). When `k` has been 0 for `DB_CYC` consecutive cycles, go to IDLE, clear `key_level` and `key_long`, pulse `release_pulse`.
- Long-press counter:
  - Counts every cycle that `key_level`=1, including RELEASE_DB.
  - Saturates at `LONG_CYC`.
  - Clears when `key_level` falls.
  - When it reaches `LONG_CYC`, `long_pulse` fires once and `key_long` sets.
  - At most one `long_pulse` per press.
- Simultaneous events:
  - If the long threshold and the release debounce completion land on the same cycle, release wins: `release_pulse`=1, `long_pulse`=0, `key_long` stays 0.
  - `press_pulse` and `release_pulse` are never high together.
- All outputs are registered.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, counters 0.
  - Synchroniser flops loaded with the idle pin level (1 if `ACTIVE_LOW`).
- Press latency: a raw press stable from cycle N gives `key_level`=1 and `press_pulse`=1 on cycle N+2+`DB_CYC`. The same rule applies to release.
- Long latency: `long_pulse` occurs `LONG_CYC` cycles after the `press_pulse` cycle.
- Bounce: any opposite sample restarts debounce from 0. A glitch shorter than `DB_CYC` cycles produces no output change.
- Reset mid-press:
  - Outputs drop to 0 asynchronously.
  - After deassertion, a still-held key needs a full fresh debounce and then produces a new `press_pulse`.
  - No `release_pulse` is generated by reset.

## Structure
- Shared package `green_machine_pkg`:
  - FSM state enum `key_state_t`.
  - Function `ms_to_cycles(clk_hz, ms)`.
- One sub-module `key_sync`: a parameterised 2-FF synchroniser with reset value `RST_VAL`.

## Test plan
All scenarios use `CLK_HZ`=1000, `DEBOUNCE_MS`=5, `LONG_MS`=20, so `DB_CYC`=5 and `LONG_CYC`=20.
- Reset, pin held 1: after reset all outputs are 0. A 4-cycle low glitch gives no output change.
- Clean press at cycle 10: `key_level` and `press_pulse` at cycle 17, `press_pulse` 1 cycle wide. Release at cycle 30: `release_pulse` and `key_level`=0 at cycle 37.
- Press with 3 bounces of 2 cycles each: exactly one `press_pulse`, 5 cycles after the last bounce clears plus sync delay.
- 40-cycle hold: `long_pulse` 20 cycles after `press_pulse`, `key_long`=1 until `release_pulse`, exactly one `long_pulse`.
- Release debounce completing on the same cycle as the long threshold: `release_pulse`=1, `long_pulse`=0.
- Reset asserted mid-hold, key kept pressed: outputs go 0 immediately. A new `press_pulse` appears 7 cycles after deassert; no `release_pulse`.

Source files
------------

// File: rtl/green_machine_pkg.sv
// Shared types and helpers for the GreenMachine board-interface logic.
// Holds the key FSM encoding and the ms-to-cycles conversion.
package green_machine_pkg;

  typedef enum logic [1:0] {
    KS_IDLE       = 2'd0,
    KS_PRESS_DB   = 2'd1,
    KS_PRESSED    = 2'd2,
    KS_RELEASE_DB = 2'd3
  } key_state_t;

  function automatic int ms_to_cycles(
    input int clk_hz,
    input int ms
  );
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ctrl_if.sv
// Key pin in, conditioned level and event pulses out.
// master drives the pin and observes; slave is the debouncer.
interface key_debounce_ctrl_if;

  logic key_raw;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic key_long;

  modport master (
    output key_raw,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  key_long
  );

  modport slave (
    input  key_raw,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output key_long
  );

endinterface

// File: rtl/key_debounce_ctrl_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset loads RST_VAL so the idle pin level is seen from reset.
module key_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {2{RST_VAL}};
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/key_debounce_ctrl.sv
// Push-button conditioner: sync, debounce, press/release/long events.
// Every output is a flop; release beats a coincident long threshold.
module key_debounce_ctrl
  import green_machine_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic clk_clk,
  input logic reset_reset,
  key_debounce_ctrl_if.slave kif
);

  localparam int DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int CW       = $clog2(LONG_CYC + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYC);

  localparam logic [1:0] S_IDLE = KS_IDLE;
  localparam logic [1:0] S_PDB  = KS_PRESS_DB;
  localparam logic [1:0] S_PRS  = KS_PRESSED;
  localparam logic [1:0] S_RDB  = KS_RELEASE_DB;

  if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_bad_cfg
    $error("key_debounce_ctrl: need DB_CYC >= 1 and LONG_CYC > DB_CYC");
  end

  logic          key_s;
  logic          k;
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_n;
  logic [CW-1:0] lcnt;
  logic [CW-1:0] lcnt_n;
  logic          level_q;
  logic          level_n;
  logic          press_q;
  logic          press_n;
  logic          rel_q;
  logic          rel_n;
  logic          long_q;
  logic          long_n;
  logic          klong_q;
  logic          klong_n;

  key_sync #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk_clk),
    .rst (reset_reset),
    .d   (kif.key_raw),
    .q   (key_s)
  );

  assign k = key_s ^ ACTIVE_LOW;

  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    level_n = level_q;
    press_n = 1'b0;
    rel_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (k) begin
          state_n = S_PDB;
          db_n    = '0;
        end
      end
      S_PDB: begin
        if (!k) begin
          state_n = S_IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_n = S_PRS;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      S_PRS: begin
        if (!k) begin
          state_n = S_RDB;
          db_n    = '0;
        end
      end
      S_RDB: begin
        if (k) begin
          state_n = S_PRS;
        end else if (db_cnt == DB_LAST) begin
          state_n = S_IDLE;
          level_n = 1'b0;
          rel_n   = 1'b1;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Hold timer runs on the debounced level, so release debounce still counts.
  always_comb begin
    lcnt_n  = lcnt;
    long_n  = 1'b0;
    klong_n = klong_q;
    if (rel_n) begin
      lcnt_n  = '0;
      klong_n = 1'b0;
    end else if (!level_q) begin
      lcnt_n = '0;
    end else if (lcnt != LONG_MAX) begin
      lcnt_n = lcnt + 1'b1;
      if (lcnt == LONG_LAST) begin
        long_n  = 1'b1;
        klong_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state   <= S_IDLE;
      db_cnt  <= '0;
      lcnt    <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      klong_q <= 1'b0;
    end else begin
      state   <= state_n;
      db_cnt  <= db_n;
      lcnt    <= lcnt_n;
      level_q <= level_n;
      press_q <= press_n;
      rel_q   <= rel_n;
      long_q  <= long_n;
      klong_q <= klong_n;
    end
  end

  assign kif.key_level     = level_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = rel_q;
  assign kif.long_pulse    = long_q;
  assign kif.key_long      = klong_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Scoreboard bench for key_debounce_ctrl with DB_CYC=5, LONG_CYC=20.
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_key_debounce_ctrl;

  typedef struct {
    int         cyc;
    logic [2:0] ev;
    logic       lvl;
    logic       lng;
  } exp_t;

  localparam logic [2:0] EV_PRESS = 3'b100;
  localparam logic [2:0] EV_REL   = 3'b010;
  localparam logic [2:0] EV_LONG  = 3'b001;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  key_debounce_ctrl_if kif();

  key_debounce_ctrl #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (5),
    .LONG_MS     (20),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .kif         (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  task automatic expect_ev(input int c, input logic [2:0] ev,
                           input logic lvl, input logic lng);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    e.lvl = lvl;
    e.lng = lng;
    q.push_back(e);
  endtask

  // Monitor: any pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [2:0] ev;
    exp_t e;
    ev = {kif.press_pulse, kif.release_pulse, kif.long_pulse};
    if (ev != 3'b000) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got ev=%b at cycle %0d, none expected",
                 ev, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ev != ev ||
            e.lvl !== kif.key_level || e.lng !== kif.key_long) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d ev=%b lvl=%b lng=%b expected cyc=%0d ev=%b lvl=%b lng=%b",
                   cyc, ev, kif.key_level, kif.key_long,
                   e.cyc, e.ev, e.lvl, e.lng);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    kif.key_raw = 1'b1;

    // Reset state, then a short low glitch.
    at_cycle(4);
    check("rst_level", kif.key_level, 1'b0);
    check("rst_press", kif.press_pulse, 1'b0);
    check("rst_rel", kif.release_pulse, 1'b0);
    check("rst_long", kif.long_pulse, 1'b0);
    check("rst_klong", kif.key_long, 1'b0);
    at_cycle(5);
    rst = 1'b0;
    b = cyc;
    at_cycle(b + 5);
    kif.key_raw = 1'b0;
    at_cycle(b + 9);
    kif.key_raw = 1'b1;
    at_cycle(b + 20);
    check("glitch_level", kif.key_level, 1'b0);

    // Clean press and release.
    b = cyc + 5;
    at_cycle(b + 10);
    kif.key_raw = 1'b0;
    expect_ev(b + 17, EV_PRESS, 1'b1, 1'b0);
    at_cycle(b + 30);
    kif.key_raw = 1'b1;
    expect_ev(b + 37, EV_REL, 1'b0, 1'b0);
    at_cycle(b + 45);

    // Press with three 2-cycle bounces.
    b = cyc + 5;
    at_cycle(b + 10); kif.key_raw = 1'b0;
    at_cycle(b + 12); kif.key_raw = 1'b1;
    at_cycle(b + 14); kif.key_raw = 1'b0;
    at_cycle(b + 16); kif.key_raw = 1'b1;
    at_cycle(b + 18); kif.key_raw = 1'b0;
    at_cycle(b + 20); kif.key_raw = 1'b1;
    at_cycle(b + 22); kif.key_raw = 1'b0;
    expect_ev(b + 29, EV_PRESS, 1'b1, 1'b0);
    at_cycle(b + 40);
    kif.key_raw = 1'b1;
    expect_ev(b + 47, EV_REL, 1'b0, 1'b0);
    at_cycle(b + 55);

    // 40-cycle hold with a long press.
    b = cyc + 5;
    at_cycle(b + 10);
    kif.key_raw = 1'b0;
    expect_ev(b + 17, EV_PRESS, 1'b1, 1'b0);
    expect_ev(b + 37, EV_LONG, 1'b1, 1'b1);
    at_cycle(b + 45);
    check("long_hold_klong", kif.key_long, 1'b1);
    at_cycle(b + 50);
    kif.key_raw = 1'b1;
    expect_ev(b + 57, EV_REL, 1'b0, 1'b0);
    at_cycle(b + 65);

    // Release completes on the long threshold cycle.
    b = cyc + 5;
    at_cycle(b + 10);
    kif.key_raw = 1'b0;
    expect_ev(b + 17, EV_PRESS, 1'b1, 1'b0);
    at_cycle(b + 30);
    kif.key_raw = 1'b1;
    expect_ev(b + 37, EV_REL, 1'b0, 1'b0);
    at_cycle(b + 40);
    check("tie_klong", kif.key_long, 1'b0);
    check("tie_level", kif.key_level, 1'b0);
    at_cycle(b + 50);

    // Reset mid-hold with key still pressed.
    b = cyc + 5;
    at_cycle(b + 10);
    kif.key_raw = 1'b0;
    expect_ev(b + 17, EV_PRESS, 1'b1, 1'b0);
    at_cycle(b + 24);
    check("pre_rst_level", kif.key_level, 1'b1);
    at_cycle(b + 25);
    rst = 1'b1;
    #1;
    check("async_rst_level", kif.key_level, 1'b0);
    at_cycle(b + 30);
    rst = 1'b0;
    expect_ev(b + 37, EV_PRESS, 1'b1, 1'b0);
    at_cycle(b + 45);
    kif.key_raw = 1'b1;
    expect_ev(b + 52, EV_REL, 1'b0, 1'b0);
    at_cycle(b + 70);

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d pending events expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
